// File: rtl/adaptor_pkg.sv
// Shared types and default widths for the cacheline-to-memory burst adaptor.
package adaptor_pkg;

  localparam int unsigned DEFAULT_LINE_W = 256;
  localparam int unsigned DEFAULT_BUS_W  = 32;
  localparam int unsigned DEFAULT_ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } adaptor_state_t;

endpackage

// File: rtl/burst_counter.sv
// Beat counter for one line burst; saturates on the final beat instead of wrapping.
module burst_counter #(
  parameter int unsigned BEATS = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       inc,
  output logic [$clog2(BEATS)-1:0]   count,
  output logic                       last
);

  localparam int unsigned CNT_W = $clog2(BEATS);

  // last is registered alongside count so it is valid in the same cycle as the final beat
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
      last  <= 1'b0;
    end else if (inc && !last) begin
      count <= count + CNT_W'(1);
      last  <= (count == CNT_W'(BEATS - 2));
    end
  end

endmodule

// File: rtl/burst_line_adaptor.sv
// Splits cacheline fills/writebacks into BEATS sequential memory-bus beats.
module burst_line_adaptor
  import adaptor_pkg::*;
#(
  parameter int unsigned LINE_W = DEFAULT_LINE_W,
  parameter int unsigned BUS_W  = DEFAULT_BUS_W,
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 line_read,
  input  logic                 line_write,
  input  logic [ADDR_W-1:0]    line_addr,
  input  logic [LINE_W-1:0]    line_wdata,
  output logic [LINE_W-1:0]    line_rdata,
  output logic                 line_resp,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [ADDR_W-1:0]    mem_address,
  output logic [BUS_W-1:0]     mem_wdata,
  output logic [BUS_W/8-1:0]   mem_byte_enable,
  input  logic [BUS_W-1:0]     mem_rdata,
  input  logic                 mem_resp
);

  localparam int unsigned BEATS      = LINE_W / BUS_W;
  localparam int unsigned BEAT_BYTES = BUS_W / 8;
  localparam int unsigned LINE_BYTES = LINE_W / 8;
  localparam int unsigned CNT_W      = $clog2(BEATS);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_BYTES - 1);

  adaptor_state_t          state;
  logic [LINE_W-BUS_W-1:0] wbuf;
  logic [CNT_W-1:0]        count;
  logic                    last;
  logic                    beat_done;
  logic                    cnt_clear;

  assign beat_done = mem_resp && ((state == READ) || (state == WRITE));
  assign cnt_clear = (state == IDLE);

  burst_counter #(
    .BEATS(BEATS)
  ) u_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (cnt_clear),
    .inc   (beat_done),
    .count (count),
    .last  (last)
  );

  // wbuf holds the not-yet-issued beats, lowest next, so mem_wdata stays put across stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      line_rdata      <= '0;
      line_resp       <= 1'b0;
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_address     <= '0;
      mem_wdata       <= '0;
      mem_byte_enable <= '0;
      wbuf            <= '0;
    end else begin
      line_resp <= 1'b0;
      case (state)
        IDLE: begin
          if (line_write || line_read) begin
            mem_address <= line_addr & ~OFF_MASK;
            mem_wdata   <= line_wdata[BUS_W-1:0];
            wbuf        <= line_wdata[LINE_W-1:BUS_W];
            if (line_write) begin
              state           <= WRITE;
              mem_write       <= 1'b1;
              mem_byte_enable <= '1;
            end else begin
              state    <= READ;
              mem_read <= 1'b1;
            end
          end
        end
        READ: begin
          if (mem_resp) begin
            for (int k = 0; k < int'(BEATS); k++) begin
              if (count == CNT_W'(k)) begin
                line_rdata[k*BUS_W +: BUS_W] <= mem_rdata;
              end
            end
            if (last) begin
              state     <= DONE;
              mem_read  <= 1'b0;
              line_resp <= 1'b1;
            end else begin
              mem_address <= mem_address + ADDR_W'(BEAT_BYTES);
            end
          end
        end
        WRITE: begin
          if (mem_resp) begin
            if (last) begin
              state           <= DONE;
              mem_write       <= 1'b0;
              mem_byte_enable <= '0;
              line_resp       <= 1'b1;
            end else begin
              mem_address <= mem_address + ADDR_W'(BEAT_BYTES);
              mem_wdata   <= wbuf[BUS_W-1:0];
              wbuf        <= wbuf >> BUS_W;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_burst_line_adaptor.sv
// Scoreboard bench for burst_line_adaptor: default 256/32 instance plus a 512/64 instance.
module tb_burst_line_adaptor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         req_read;
  logic         req_write;
  logic         wide;
  logic         resp;
  logic [31:0]  addr;
  logic [511:0] wdata;
  logic [63:0]  rdata;

  logic [255:0] n_line_rdata;
  logic         n_line_resp, n_mem_read, n_mem_write;
  logic [31:0]  n_mem_address, n_mem_wdata;
  logic [3:0]   n_be;

  logic [511:0] w_line_rdata;
  logic         w_line_resp, w_mem_read, w_mem_write;
  logic [31:0]  w_mem_address;
  logic [63:0]  w_mem_wdata;
  logic [7:0]   w_be;

  logic [511:0] o_line_rdata;
  logic         o_line_resp, o_mem_read, o_mem_write;
  logic [31:0]  o_mem_address;
  logic [63:0]  o_mem_wdata;
  logic [7:0]   o_be;

  burst_line_adaptor dut (
    .clk             (clk),
    .rst             (rst),
    .line_read       (req_read & ~wide),
    .line_write      (req_write & ~wide),
    .line_addr       (addr),
    .line_wdata      (wdata[255:0]),
    .line_rdata      (n_line_rdata),
    .line_resp       (n_line_resp),
    .mem_read        (n_mem_read),
    .mem_write       (n_mem_write),
    .mem_address     (n_mem_address),
    .mem_wdata       (n_mem_wdata),
    .mem_byte_enable (n_be),
    .mem_rdata       (rdata[31:0]),
    .mem_resp        (resp & ~wide)
  );

  burst_line_adaptor #(
    .LINE_W (512),
    .BUS_W  (64),
    .ADDR_W (32)
  ) dut_wide (
    .clk             (clk),
    .rst             (rst),
    .line_read       (req_read & wide),
    .line_write      (req_write & wide),
    .line_addr       (addr),
    .line_wdata      (wdata),
    .line_rdata      (w_line_rdata),
    .line_resp       (w_line_resp),
    .mem_read        (w_mem_read),
    .mem_write       (w_mem_write),
    .mem_address     (w_mem_address),
    .mem_wdata       (w_mem_wdata),
    .mem_byte_enable (w_be),
    .mem_rdata       (rdata),
    .mem_resp        (resp & wide)
  );

  always_comb begin
    o_line_rdata  = wide ? w_line_rdata  : {256'b0, n_line_rdata};
    o_line_resp   = wide ? w_line_resp   : n_line_resp;
    o_mem_read    = wide ? w_mem_read    : n_mem_read;
    o_mem_write   = wide ? w_mem_write   : n_mem_write;
    o_mem_address = wide ? w_mem_address : n_mem_address;
    o_mem_wdata   = wide ? w_mem_wdata   : {32'b0, n_mem_wdata};
    o_be          = wide ? w_be          : {4'b0, n_be};
  end

  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
  } beat_t;

  beat_t        beat_q[$];
  logic [511:0] line_q[$];
  logic [511:0] n_model;
  logic [511:0] w_model;
  int           n_checks;
  int           n_fail;

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_line_resp"}, 512'(o_line_resp), 512'(0));
    check_eq({tag, "_mem_read"}, 512'(o_mem_read), 512'(0));
    check_eq({tag, "_mem_write"}, 512'(o_mem_write), 512'(0));
    check_eq({tag, "_mem_address"}, 512'(o_mem_address), 512'(0));
    check_eq({tag, "_mem_wdata"}, 512'(o_mem_wdata), 512'(0));
    check_eq({tag, "_byte_enable"}, 512'(o_be), 512'(0));
    check_eq({tag, "_line_rdata"}, o_line_rdata, 512'(0));
  endtask

  // One line transaction; memory answers each beat after `stall` idle cycles.
  // abort_at >= 0 pulses rst instead of answering that beat.
  task automatic run_burst(input bit is_write, input bit both, input logic [31:0] a,
                           input int stall, input int abort_at);
    beat_t        b;
    logic [31:0]  base;
    logic [511:0] line;
    logic [63:0]  d;
    int           bb;
    int           cyc;
    bb    = wide ? 8 : 4;
    base  = a & (wide ? ~32'h3F : ~32'h1F);
    line  = wide ? w_model : n_model;
    wdata = '0;
    for (int k = 0; k < 8; k++) begin
      if (is_write)
        d = wide ? 64'h1111_1111_1111_1111 * 64'(k) : 64'(32'h1111_1111 * 32'(k));
      else
        d = wide ? {32'hB000_0000 + 32'(k), 32'hA000_0000 + 32'(k)}
                 : 64'(32'hA000_0000 + 32'(k));
      b.addr = base + 32'(k * bb);
      b.data = d;
      beat_q.push_back(b);
      if (wide) begin
        if (is_write) wdata[k*64 +: 64] = d;
        else          line[k*64 +: 64]  = d;
      end else begin
        if (is_write) wdata[k*32 +: 32] = d[31:0];
        else          line[k*32 +: 32]  = d[31:0];
      end
    end
    line_q.push_back(line);

    addr      = a;
    req_write = is_write;
    req_read  = !is_write || both;
    cyc       = 0;
    @(negedge clk);
    cyc       = 1;
    req_read  = 1'b0;
    req_write = 1'b0;

    for (int k = 0; k < 8; k++) begin
      if (k == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("abort");
        beat_q.delete();
        line_q.delete();
        n_model = '0;
        w_model = '0;
        return;
      end
      b = beat_q.pop_front();
      for (int s = 0; s <= stall; s++) begin
        check_eq("mem_read", 512'(o_mem_read), 512'(!is_write));
        check_eq("mem_write", 512'(o_mem_write), 512'(is_write));
        check_eq("mem_address", 512'(o_mem_address), 512'(b.addr));
        check_eq("byte_enable", 512'(o_be),
                 512'(is_write ? (wide ? 8'hFF : 8'h0F) : 8'h00));
        if (is_write) check_eq("mem_wdata", 512'(o_mem_wdata), 512'(b.data));
        if (s == stall) begin
          resp  = 1'b1;
          rdata = b.data;
        end
        @(negedge clk);
        cyc++;
        resp = 1'b0;
      end
    end

    check_eq("line_resp", 512'(o_line_resp), 512'(1));
    check_eq("resp_cycle", 512'(cyc), 512'(1 + 8 * (stall + 1)));
    check_eq("line_rdata", o_line_rdata, line_q.pop_front());
    check_eq("done_no_req", 512'(o_mem_read | o_mem_write), 512'(0));
    if (wide) w_model = line;
    else      n_model = line;
    @(negedge clk);
    check_eq("line_resp_pulse", 512'(o_line_resp), 512'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit hit before test end");
    $fatal(1);
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    n_model   = '0;
    w_model   = '0;
    rst       = 1'b1;
    req_read  = 1'b0;
    req_write = 1'b0;
    wide      = 1'b0;
    resp      = 1'b0;
    addr      = '0;
    wdata     = '0;
    rdata     = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    check_eq("reset_wide_line_rdata", w_line_rdata, 512'(0));
    check_eq("reset_wide_req", 512'({w_mem_read, w_mem_write, w_line_resp}), 512'(0));

    // stray memory response in IDLE must be ignored
    rst  = 1'b0;
    resp = 1'b1;
    @(negedge clk);
    resp = 1'b0;
    @(negedge clk);
    check_all_zero("idle_resp");

    run_burst(1'b0, 1'b0, 32'h0000_1234, 0, -1);
    run_burst(1'b1, 1'b0, 32'h0000_0040, 0, -1);
    run_burst(1'b0, 1'b0, 32'h0000_2000, 3, -1);

    // simultaneous requests: writeback only, fill waits for a fresh request
    run_burst(1'b1, 1'b1, 32'h0000_0080, 0, -1);
    repeat (3) begin
      @(negedge clk);
      check_eq("dropped_read", 512'({o_mem_read, o_mem_write}), 512'(0));
    end
    run_burst(1'b0, 1'b0, 32'h0000_0080, 0, -1);

    run_burst(1'b0, 1'b0, 32'h0000_3000, 0, 4);
    run_burst(1'b0, 1'b0, 32'h0000_1234, 1, -1);

    wide = 1'b1;
    @(negedge clk);
    run_burst(1'b0, 1'b0, 32'h0000_1010, 0, -1);
    run_burst(1'b1, 1'b0, 32'h0000_2040, 1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/burst_line_adaptor.md
BURST_LINE_ADAPTOR -- requirements
Module: burst_line_adaptor

Interface
REQ-001 SHALL have parameter LINE_W, default 256, meaning cacheline width in bits.
REQ-002 SHALL have parameter BUS_W, default 32, meaning memory data bus width in bits; LINE_W a multiple of BUS_W; BUS_W a multiple of 8.
REQ-003 SHALL have parameter ADDR_W, default 32, meaning byte address width.
REQ-004 SHALL derive BEATS = LINE_W/BUS_W and BEAT_BYTES = BUS_W/8; BEATS a power of two, at least 2.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 line_read  input  1  cache requests line fill.
REQ-008 line_write  input  1  cache requests line writeback.
REQ-009 line_addr  input  ADDR_W  line byte address; low log2(LINE_W/8) bits ignored.
REQ-010 line_wdata  input  LINE_W  writeback line data.
REQ-011 line_rdata  output  LINE_W  assembled fill data.
REQ-012 line_resp  output  1  one-cycle completion pulse.
REQ-013 mem_read  output  1  beat read request to memory.
REQ-014 mem_write  output  1  beat write request to memory.
REQ-015 mem_address  output  ADDR_W  beat byte address.
REQ-016 mem_wdata  output  BUS_W  beat write data.
REQ-017 mem_byte_enable  output  BUS_W/8  beat byte enables.
REQ-018 mem_rdata  input  BUS_W  beat read data, valid with mem_resp.
REQ-019 mem_resp  input  1  memory completes current beat.

Function
REQ-020 SHALL implement FSM states IDLE, READ, WRITE, DONE.
REQ-021 IDLE: line_write=1 -> WRITE; else line_read=1 -> READ; both asserted -> WRITE (writeback before fill); requests sampled only in IDLE.
REQ-022 On leaving IDLE SHALL latch aligned base address, line_wdata, and clear beat counter to 0.
REQ-023 READ/WRITE: mem_read (resp. mem_write) held at 1 every cycle of the state until the final beat's mem_resp; mem_address = base + beat*BEAT_BYTES.
REQ-024 Each cycle with mem_resp=1 in READ/WRITE SHALL complete exactly one beat and increment the counter; mem_resp outside READ/WRITE SHALL be ignored.
REQ-025 READ: beat k SHALL capture mem_rdata into line_rdata[k*BUS_W +: BUS_W].
REQ-026 WRITE: mem_wdata = latched line_wdata[beat*BUS_W +: BUS_W]; mem_byte_enable all ones; mem_byte_enable all zeros in READ/IDLE/DONE.
REQ-027 mem_resp on beat BEATS-1 -> DONE next cycle; counter SHALL not wrap into a further beat.
REQ-028 DONE: line_resp=1 for exactly one cycle, then IDLE unconditionally; line_rdata complete in that cycle.
REQ-029 line_rdata SHALL hold its value until the next READ overwrites beats; unchanged by WRITE.
REQ-030 Latency: request at cycle 0, memory responding every cycle -> first beat request cycle 1, line_resp at cycle BEATS+1.
REQ-031 mem_wdata/mem_address SHALL be stable while a beat awaits mem_resp (memory stalls of any length).
REQ-032 mem_read and mem_write SHALL never be 1 simultaneously.

Reset
REQ-033 rst=1 SHALL force IDLE, counter 0, line_rdata 0, line_resp 0, mem_read 0, mem_write 0, mem_address 0, mem_wdata 0, mem_byte_enable 0 at the next edge.
REQ-034 rst mid-burst SHALL abort with no line_resp; partial line_rdata discarded (cleared).
REQ-035 Requests present in the cycle rst deasserts SHALL be honoured the following cycle.

Structure
REQ-036 Shared package adaptor_pkg SHALL hold the state enum type and default width constants; BEATS/BEAT_BYTES remain module localparams.
REQ-037 Beat counter with terminal-count flag SHALL be sub-module burst_counter (parameter BEATS, ports clk, rst, clear, inc, count, last).

Verification
REQ-038 Defaults, line_read, addr 0x0000_1234, memory returns beat k = 0xA000_0000+k with resp every cycle -> addresses 0x1220..0x123C, line_resp at cycle 9, line_rdata beat k = 0xA000_000k.
REQ-039 line_write, addr 0x40, line_wdata beat k = 0x1111_1111*k -> 8 writes to 0x40..0x5C, data matches, byte_enable 0xF, single line_resp.
REQ-040 Fill with 3-cycle stall before every mem_resp -> address/request stable during stall, line_resp at cycle 1+8*4.
REQ-041 line_read and line_write both 1 in IDLE -> WRITE burst first, no mem_read; read served only after re-request.
REQ-042 rst asserted after beat 3 of a fill -> next cycle all outputs 0, no line_resp; subsequent fill completes correctly.
REQ-043 LINE_W=512, BUS_W=64 -> 8 beats, address step 8, byte_enable 0xFF, data placement correct.
